// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: issues one aligned data-memory access per instruction,
// formats load data, and stalls the upstream pipeline while the access is outstanding.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [2:0]  DMType_in,
    input  logic [31:0] alures_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    input  logic        RegWrite_in,
    input  logic [2:0]  WDSel_in,
    input  logic [31:0] PC_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] alures_out,
    output logic [4:0]  rd_out,
    output logic [2:0]  WDSel_out,
    output logic        RegWrite_out,
    output logic [31:0] read_data_out,
    output logic        stall_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      read_data_q, read_data_d;
    logic [31:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [2:0]       dmtype_q, dmtype_d;

    logic        mem_op, is_byte, is_half, misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_rep;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // Size decode ignores funct3[2]; codes 011/110/111 therefore fall through to word.
    assign mem_op     = valid_in & (MemRead_in | MemWrite_in);
    assign is_byte    = (DMType_in[1:0] == 2'b00);
    assign is_half    = (DMType_in[1:0] == 2'b01);
    assign misaligned = is_half ? alures_in[0] : (!is_byte && (alures_in[1:0] != 2'b00));

    always_comb begin
        be_in     = 4'b1111;
        wdata_rep = wdata_in;
        if (is_byte) begin
            be_in     = 4'b0001 << alures_in[1:0];
            wdata_rep = {4{wdata_in[7:0]}};
        end else if (is_half) begin
            be_in     = 4'b0011 << {alures_in[1], 1'b0};
            wdata_rep = {2{wdata_in[15:0]}};
        end
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (dmtype_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            read_data_q <= 32'd0;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            dmtype_q    <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            dmtype_q    <= dmtype_d;
        end
    end

    // Counter is loaded with 1 on entry so it equals the current BUSY cycle number.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        read_data_d = read_data_q;
        addr_d      = addr_q;
        we_d        = we_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        dmtype_d    = dmtype_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    addr_d   = alures_in;
                    we_d     = MemWrite_in;
                    be_d     = be_in;
                    wdata_d  = wdata_rep;
                    dmtype_d = DMType_in;
                    cnt_d    = CNT_W'(1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ready) begin
                    if (!we_q) read_data_d = load_fmt;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    read_data_d = 32'd0;
                    err_d       = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req     = (state_q == BUSY);
        stall_out    = (state_q == BUSY) || ((state_q == IDLE) && mem_op && !misaligned);
        misalign_out = (state_q == IDLE) && mem_op && misaligned;
        bus_err_out  = (state_q == DONE) && err_q;
    end

    assign dmem_we       = we_q;
    assign dmem_addr     = {addr_q[31:2], 2'b00};
    assign dmem_wdata    = wdata_q;
    assign dmem_be       = be_q;
    assign read_data_out = read_data_q;

    assign PC_out       = PC_in;
    assign alures_out   = alures_in;
    assign rd_out       = rd_in;
    assign WDSel_out    = WDSel_in;
    assign RegWrite_out = RegWrite_in & valid_in & !stall_out & !misalign_out & !bus_err_out;

endmodule
